// File: rtl/rr_pkg.sv
// Shared types and constants for the round-robin grant selector.
// Imported by rr_pick4 and rr_grant_sel.
package rr_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set request after `last`,
// wrapping 3->0; `any` flags that some request is set.
module rr_pick4
  import rr_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] j;

  // Scan last+1 .. last+4; the first hit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      j = last + IDX_W'(i);
      if (req[j] && !any) begin
        idx = j;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_sel.sv
// Four-way round-robin arbiter feeding a 2-to-4 decoder index.
// Define RR_TIMEOUT_EN to add the hold counter and forced release.
module rr_grant_sel
  import rr_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             busy,
  output logic             timeout
);

  state_t           state, state_n;
  logic [IDX_W-1:0] last, last_n;
  logic [IDX_W-1:0] idx_n;
  logic [IDX_W-1:0] pick_last, pick_idx;
  logic             pick_any;
  logic             vld_n, busy_n, to_n;
  logic             drop, to_hit;

  // In RELEASE the pointer is already the outgoing owner.
  assign pick_last = (state == RELEASE) ? gnt_idx : last;
  assign drop      = !req[gnt_idx];

  rr_pick4 u_pick (
    .req  (req),
    .last (pick_last),
    .idx  (pick_idx),
    .any  (pick_any)
  );

`ifdef RR_TIMEOUT_EN
  logic [CNT_W-1:0] cnt, cnt_n;

  assign to_hit = (cnt == CNT_W'(HOLD_MAX));

  // Hold counter runs only while a grant is held.
  always_comb begin
    cnt_n = '0;
    if (state == GRANT)
      cnt_n = cnt + CNT_W'(1);
  end

  // Hold counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_n;
  end
`else
  logic unused_cfg;

  assign to_hit     = 1'b0;
  assign unused_cfg = ^{32'(HOLD_MAX), 32'(CNT_W)};
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_n = state;
    last_n  = last;
    idx_n   = gnt_idx;
    vld_n   = gnt_vld;
    busy_n  = busy;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_n = GRANT;
          idx_n   = pick_idx;
          vld_n   = 1'b1;
          busy_n  = 1'b1;
        end
      end
      GRANT: begin
        if (done || drop || to_hit) begin
          state_n = RELEASE;
          vld_n   = 1'b0;
          to_n    = !done && !drop;
        end
      end
      RELEASE: begin
        last_n = gnt_idx;
        if (pick_any) begin
          state_n = GRANT;
          idx_n   = pick_idx;
          vld_n   = 1'b1;
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        vld_n   = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last    <= IDX_W'(N_REQ - 1);
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      last    <= last_n;
      gnt_idx <= idx_n;
      gnt_vld <= vld_n;
      busy    <= busy_n;
      timeout <= to_n;
    end
  end

endmodule

// File: doc/rr_grant_sel.md
# rr_grant_sel

Four-requester round-robin arbiter that produces the 2-bit grant index driven into the 2-to-4 decoder (`gnt_idx[1]` → `a`, `gnt_idx[0]` → `b`). The decoder's one-hot outputs then become the per-requester enables. The block holds a grant until the owner finishes, drops its request or, optionally, times out. Grants rotate fairly so no requester starves.

## Interface
Parameters:
- `HOLD_MAX`, default 15: maximum cycles a grant may stay in GRANT before forced release (timeout build only).
- `CNT_W`, default 4: hold-counter width; must satisfy `HOLD_MAX < 2**CNT_W`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  4  request lines, bit i = requester i, level-sensitive.
- `done`  in  1  current owner signals completion; sampled only in GRANT.
- `gnt_idx`  out  2  index of current owner; msb → decoder `a`, lsb → decoder `b`.
- `gnt_vld`  out  1  grant active; the decoder output is meaningful only while high.
- `busy`  out  1  high in GRANT or RELEASE.
- `timeout`  out  1  one-cycle pulse when a grant is force-released.

## Operation
- States: IDLE, GRANT, RELEASE.
- Rotating pointer `last` (2 bits) holds the most recently released owner. The winner is the first set `req` bit searched from `last+1` upward, wrapping 3→0.
- IDLE: if any `req` is set, latch winner into `gnt_idx`, clear hold counter, go to GRANT. Otherwise stay.
- GRANT: `gnt_vld`=1. The hold counter increments each cycle. Exit to RELEASE when any of these holds:
  - `done`=1;
  - `req[gnt_idx]`=0;
  - (timeout build) hold count = `HOLD_MAX`, which also pulses `timeout`.
- RELEASE: `gnt_vld`=0 and `last` ← `gnt_idx`. If any `req` is set, pick a new winner using the updated pointer and go directly to GRANT. Otherwise go to IDLE.
- `gnt_idx` holds its last value while `gnt_vld`=0. Consumers must qualify on `gnt_vld`.
- Priority among simultaneous exit causes: `done` > request drop > timeout. `timeout` pulses only if neither of the others is present that cycle.
- A lone requester re-wins after every release. It gets the grant again after a 1-cycle gap.

## Timing
- Reset values: state=IDLE, `last`=3 (so requester 0 has first priority), `gnt_idx`=0, `gnt_vld`=0, `busy`=0, `timeout`=0, hold counter=0.
- All outputs are registered.
- Request-to-grant latency: `req` set in cycle n (IDLE) → `gnt_vld`=1 in n+1.
- Release: exit cause in cycle n → `gnt_vld`=0 in n+1. The next owner has `gnt_vld`=1 in n+2, so there is exactly one idle-grant cycle between owners.
- Timeout: `gnt_vld` rises in cycle g → `timeout`=1 in cycle g+`HOLD_MAX`+1 together with `gnt_vld`=0.
- Reset mid-grant: all outputs go to reset values immediately (asynchronous), with no RELEASE cycle. The pointer returns to 3.
- Requests asserted during RELEASE are eligible in that same cycle's arbitration.

## Configuration
- `RR_TIMEOUT_EN` defined: hold counter, `HOLD_MAX` check and `timeout` pulse are present.
- Not defined: no hold counter. The grant is held until `done` or request drop, `timeout` is tied 0, and `HOLD_MAX`/`CNT_W` are ignored.

## Structure
- Shared package `rr_pkg`:
  - state encoding IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2;
  - `N_REQ`=4 and `IDX_W`=2.
- One sub-module, `rr_pick4`: combinational rotating-priority picker with inputs `req[3:0]`, `last[1:0]` and outputs `idx[1:0]`, `any`. It is used in both IDLE and RELEASE.

## Test plan
- Reset, then `req`=4'b0101 → `gnt_idx`=0 with `gnt_vld`=1 one cycle later. Pulse `done` → 1 cycle with `gnt_vld`=0, then `gnt_idx`=2.
- `req`=4'b1111 held, `done` pulsed each grant → grant order 0,1,2,3,0 with a one-cycle gap between grants; the decoder outputs y0..y3 are one-hot in matching order.
- Owner 1 drops `req[1]` mid-grant with no `done` → release next cycle, `timeout`=0, and the next winner is searched from index 2.
- `RR_TIMEOUT_EN`, `HOLD_MAX`=15, `req`=4'b0001 held with no `done` → `timeout` pulses at grant cycle 16 with `gnt_vld`=0, then owner 0 is re-granted 1 cycle later. Without the macro, the grant holds for 100 cycles and `timeout` stays 0.
- `done` and timeout occur in the same cycle → release happens and `timeout` stays 0.
- Assert `rst` asynchronously mid-grant (between clock edges) → `gnt_vld`=0 and `gnt_idx`=0 immediately. After release with `req`=4'b1000, `gnt_idx`=3 one cycle later.
